// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: reset PC default, fetch FSM states, NOP word and PC stride.
package mips_pkg;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] INST_NOP     = 32'h0000_0000;
   localparam logic [31:0] PC_STEP      = 32'd4;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/ifetch_buf.sv
// Two-entry {inst, pc} FIFO between fetch and decode; flush wins over push and pop.
module ifetch_buf
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        i_push,
   input  logic [31:0] i_push_inst,
   input  logic [31:0] i_push_pc,
   input  logic        i_pop,
   input  logic        i_flush,
   output logic        o_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc,
   output logic [1:0]  o_count
);

   logic [31:0] r_inst [2];
   logic [31:0] r_pc   [2];
   logic [1:0]  r_count;

   logic        w_pop;
   logic        w_push;
   logic [1:0]  w_wr_idx;

   // Entry 0 is always the head; a pop shifts entry 1 down.
   assign w_pop    = i_pop && (r_count != 2'd0);
   assign w_push   = i_push && ((r_count != 2'd2) || w_pop);
   assign w_wr_idx = r_count - {1'b0, w_pop};

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_count <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_inst[i] <= INST_NOP;
            r_pc[i]   <= 32'h0;
         end
      end else if (i_flush) begin
         r_count <= 2'd0;
      end else begin
         if (w_pop) begin
            r_inst[0] <= r_inst[1];
            r_pc[0]   <= r_pc[1];
         end
         if (w_push) begin
            r_inst[w_wr_idx[0]] <= i_push_inst;
            r_pc[w_wr_idx[0]]   <= i_push_pc;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign o_valid = (r_count != 2'd0);
   assign o_inst  = o_valid ? r_inst[0] : INST_NOP;
   assign o_pc    = o_valid ? r_pc[0] : 32'h0;
   assign o_count = r_count;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch controller: next-PC mux, single-outstanding imem handshake FSM and decode buffer.
module ifetch_ctrl
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter int          BUF_DEPTH = 2
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [31:0]  pc,
   output logic [31:0]  npc,
   input  logic         redirect,
   input  logic [31:0]  redirect_pc,
   output logic         imem_req,
   output logic [31:0]  imem_addr,
   input  logic         imem_gnt,
   input  logic         imem_rvalid,
   input  logic [31:0]  imem_rdata,
   output logic         id_valid,
   input  logic         id_ready,
   output logic [31:0]  id_inst,
   output logic [31:0]  id_pc,
   output fetch_state_t dbg_state
);

   // Handshake: a request is accepted on a cycle where imem_req && imem_gnt;
   // its single response arrives later as an imem_rvalid pulse with imem_rdata.
   // Decode takes the head entry on any cycle where id_valid && id_ready.

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   logic [31:0]  r_req_pc;
   logic         w_req;
   logic         w_grant;
   logic         w_push;
   logic [1:0]   w_count;

   assign w_req     = (r_state == RUN) && !redirect && (w_count < 2'(BUF_DEPTH)) && !clr;
   assign w_grant   = w_req && imem_gnt;
   assign imem_req  = w_req;
   assign imem_addr = pc;
   assign dbg_state = r_state;

   always_comb begin
      npc = pc;
      if (clr)
         npc = RESET_PC;
      else if (redirect)
         npc = redirect_pc;
      else if (w_grant)
         npc = pc + PC_STEP;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      case (r_state)
         RUN: begin
            if (w_grant)
               w_state_nxt = WAIT;
         end
         WAIT: begin
            if (imem_rvalid) begin
               w_state_nxt = RUN;
               w_push      = !redirect;
            end else if (redirect) begin
               w_state_nxt = DROP;
            end
         end
         DROP: begin
            if (imem_rvalid)
               w_state_nxt = RUN;
         end
         default: w_state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state  <= RUN;
         r_req_pc <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant)
            r_req_pc <= pc;
      end
   end

   ifetch_buf u_buf (
      .clk         (clk),
      .clr         (clr),
      .i_push      (w_push),
      .i_push_inst (imem_rdata),
      .i_push_pc   (r_req_pc),
      .i_pop       (id_ready),
      .i_flush     (redirect),
      .o_valid     (id_valid),
      .o_inst      (id_inst),
      .o_pc        (id_pc),
      .o_count     (w_count)
   );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a PC register, a latency-programmable memory and a pop scoreboard.
module tb_ifetch_ctrl;
   import mips_pkg::*;

   logic         clk = 1'b0;
   logic         clr;
   logic [31:0]  pc;
   logic [31:0]  npc;
   logic         redirect;
   logic [31:0]  redirect_pc;
   logic         imem_req;
   logic [31:0]  imem_addr;
   logic         imem_gnt;
   logic         imem_rvalid = 1'b0;
   logic [31:0]  imem_rdata = 32'h0;
   logic         id_valid;
   logic         id_ready;
   logic [31:0]  id_inst;
   logic [31:0]  id_pc;
   fetch_state_t dbg_state;

   logic         pc_loop;
   logic [31:0]  pc_set;
   int           mem_lat;
   logic         mem_pend = 1'b0;
   int           mem_cnt = 0;
   logic [31:0]  mem_addr = 32'h0;

   logic [63:0]  exp_q [$];
   int           n_total = 0;
   int           n_bad = 0;

   ifetch_ctrl dut (
      .clk         (clk),
      .clr         (clr),
      .pc          (pc),
      .npc         (npc),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_inst     (id_inst),
      .id_pc       (id_pc),
      .dbg_state   (dbg_state)
   );

   // clock / environment
   always #5 clk = ~clk;

   always @(posedge clk) pc <= pc_loop ? npc : pc_set;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   always @(posedge clk) begin
      imem_rvalid <= 1'b0;
      if (mem_pend) begin
         if (mem_cnt == 1) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= inst_of(mem_addr);
            mem_pend    <= 1'b0;
         end else begin
            mem_cnt <= mem_cnt - 1;
         end
      end
      if (imem_req && imem_gnt) begin
         if (mem_lat == 1) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= inst_of(imem_addr);
         end else begin
            mem_pend <= 1'b1;
            mem_cnt  <= mem_lat - 1;
            mem_addr <= imem_addr;
         end
      end
   end

   // scoreboard monitor: every accepted pop must match the queue head
   always @(negedge clk) begin
      if (!clr && id_valid && id_ready && !redirect) begin
         n_total++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL pop_unexpected: got pc=%h inst=%h, required no pop", id_pc, id_inst);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if ({id_pc, id_inst} !== e) begin
               n_bad++;
               $display("FAIL pop_data: got pc=%h inst=%h, required pc=%h inst=%h",
                        id_pc, id_inst, e[63:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver / check tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic expect_pop(input logic [31:0] p, input logic [31:0] i);
      exp_q.push_back({p, i});
   endtask

   initial begin
      clr = 1'b1; pc_loop = 1'b0; pc_set = 32'h40; redirect = 1'b0;
      redirect_pc = 32'h0; imem_gnt = 1'b0; mem_lat = 1; id_ready = 1'b0;

      // reset
      repeat (3) tick();
      chk("rst_pc_env", pc, 32'h40);
      chk("rst_npc", npc, 32'h0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_id_valid", 32'(id_valid), 32'd0);
      chk("rst_id_inst", id_inst, 32'h0);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_state", 32'(dbg_state), 32'(RUN));
      pc_set = 32'h0;
      tick();
      clr = 1'b0; pc_loop = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1;
      #1;

      // sequential fetch, 1-cycle memory
      expect_pop(32'h0, 32'h1357_9BDF);
      expect_pop(32'h4, 32'h1357_9BDB);
      expect_pop(32'h8, 32'h1357_9BD7);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("seq_req_%0d", i), 32'(imem_req), (i % 2 == 0) ? 32'd1 : 32'd0);
         if (i == 0) chk("seq_addr_0", imem_addr, 32'h0);
         if (i == 0) chk("seq_npc_0", npc, 32'h4);
         if (i == 2) chk("seq_addr_2", imem_addr, 32'h4);
         if (i == 4) chk("seq_addr_4", imem_addr, 32'h8);
         if (i == 1) chk("seq_lat_v1", 32'(id_valid), 32'd0);
         if (i == 2) chk("seq_lat_v2", 32'(id_valid), 32'd1);
         if (i == 5) imem_gnt = 1'b0;
         tick();
      end
      chk("seq_hold_npc", npc, 32'hC);
      chk("seq_hold_req", 32'(imem_req), 32'd1);
      repeat (2) tick();
      chk("seq_drain", 32'(exp_q.size()), 32'd0);

      // backpressure
      id_ready = 1'b0; imem_gnt = 1'b1;
      expect_pop(32'hC, 32'h1357_9BD3);
      expect_pop(32'h10, 32'h1357_9BCF);
      repeat (4) tick();
      chk("bp_req_full", 32'(imem_req), 32'd0);
      chk("bp_npc_hold", npc, 32'h14);
      chk("bp_head_pc", id_pc, 32'hC);
      chk("bp_valid", 32'(id_valid), 32'd1);
      tick();
      chk("bp_req_full2", 32'(imem_req), 32'd0);
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      chk("bp_restart_req", 32'(imem_req), 32'd1);
      chk("bp_restart_addr", imem_addr, 32'h14);
      expect_pop(32'h14, 32'h1357_9BCB);
      tick();
      imem_gnt = 1'b0; id_ready = 1'b1;
      repeat (3) tick();
      chk("bp_drain", 32'(exp_q.size()), 32'd0);

      // redirect while waiting, response one cycle later
      mem_lat = 2; imem_gnt = 1'b1;
      tick();
      redirect = 1'b1; redirect_pc = 32'h100;
      #1;
      chk("rw_npc", npc, 32'h100);
      chk("rw_req", 32'(imem_req), 32'd0);
      chk("rw_state", 32'(dbg_state), 32'(WAIT));
      tick();
      redirect = 1'b0; mem_lat = 1;
      #1;
      chk("rw_drop_state", 32'(dbg_state), 32'(DROP));
      chk("rw_drop_req", 32'(imem_req), 32'd0);
      chk("rw_drop_npc", npc, 32'h100);
      chk("rw_drop_valid", 32'(id_valid), 32'd0);
      tick();
      chk("rw_run_state", 32'(dbg_state), 32'(RUN));
      chk("rw_run_valid", 32'(id_valid), 32'd0);
      chk("rw_req_after", 32'(imem_req), 32'd1);
      chk("rw_addr_after", imem_addr, 32'h100);
      expect_pop(32'h100, 32'h1357_9ADF);
      tick();
      imem_gnt = 1'b0;
      repeat (3) tick();
      chk("rw_drain", 32'(exp_q.size()), 32'd0);

      // redirect with rvalid, then redirect in RUN with a pop
      id_ready = 1'b0; imem_gnt = 1'b1;
      repeat (3) tick();
      redirect = 1'b1; redirect_pc = 32'h200;
      #1;
      chk("rr_npc", npc, 32'h200);
      chk("rr_valid_before", 32'(id_valid), 32'd1);
      tick();
      redirect = 1'b0;
      #1;
      chk("rr_flushed", 32'(id_valid), 32'd0);
      chk("rr_state", 32'(dbg_state), 32'(RUN));
      chk("rr_req_addr", imem_addr, 32'h200);
      repeat (2) tick();
      chk("rp_valid", 32'(id_valid), 32'd1);
      chk("rp_head_pc", id_pc, 32'h200);
      redirect = 1'b1; redirect_pc = 32'h300; id_ready = 1'b1;
      #1;
      chk("rp_npc", npc, 32'h300);
      chk("rp_req", 32'(imem_req), 32'd0);
      tick();
      redirect = 1'b0; imem_gnt = 1'b0; pc_loop = 1'b0; pc_set = 32'hFFFF_FFFC;
      #1;
      chk("rp_valid_after", 32'(id_valid), 32'd0);
      chk("rp_inst_after", id_inst, 32'h0);
      chk("rp_pc_after", id_pc, 32'h0);
      chk("rp_nothing_pushed", 32'(exp_q.size()), 32'd0);

      // wrap-around
      tick();
      imem_gnt = 1'b1; pc_loop = 1'b1;
      expect_pop(32'hFFFF_FFFC, 32'hECA8_6423);
      #1;
      chk("wrap_npc", npc, 32'h0);
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      tick();
      imem_gnt = 1'b0;
      #1;
      chk("wrap_hold_npc", npc, 32'h0);
      repeat (3) tick();
      chk("wrap_drain", 32'(exp_q.size()), 32'd0);

      // reset while a fetch is outstanding
      imem_gnt = 1'b1; mem_lat = 2;
      tick();
      clr = 1'b1; imem_gnt = 1'b0;
      #1;
      chk("clr_state", 32'(dbg_state), 32'(RUN));
      chk("clr_req", 32'(imem_req), 32'd0);
      chk("clr_npc", npc, 32'h0);
      tick();
      clr = 1'b0;
      #1;
      chk("clr_rvalid_env", 32'(imem_rvalid), 32'd1);
      tick();
      chk("clr_ignored_valid", 32'(id_valid), 32'd0);
      chk("clr_ignored_state", 32'(dbg_state), 32'(RUN));
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller that closes the loop around the program-counter register. It reads the current `pc` and computes the `npc` that the PC register loads on the next edge. It issues one instruction-memory request at a time with a request/grant/response handshake and buffers returned instructions in a 2-entry queue for the decode stage. Branch/jump redirects from execute override sequential fetch and flush in-flight and buffered instructions.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, value driven on `npc` while in reset; equals the PC register's reset value
- `BUF_DEPTH`, 2, instruction buffer entries; fixed at 2

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `clr`  in  1  asynchronous, active-high reset
- `pc`  in  32  current PC from PC register
- `npc`  out  32  next PC to PC register, loaded every cycle
- `redirect`  in  1  branch/jump taken in execute
- `redirect_pc`  in  32  target address for `redirect`
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  fetch address, equal to `pc`
- `imem_gnt`  in  1  memory accepts the request this cycle
- `imem_rvalid`  in  1  response valid; never earlier than 1 cycle after `imem_gnt`
- `imem_rdata`  in  32  instruction word
- `id_valid`  out  1  buffered instruction available
- `id_ready`  in  1  decode consumes the head entry
- `id_inst`  out  32  head instruction (32'h0 when empty)
- `id_pc`  out  32  address of `id_inst`

## Operation
- FSM states are `RUN`, `WAIT` and `DROP`:
  - `RUN`: no fetch outstanding.
  - `WAIT`: one fetch outstanding; its response is kept.
  - `DROP`: one fetch outstanding; its response is discarded.
- Priority for `npc` is `clr` > `redirect` > grant > hold:
  - `clr` high: `npc`=`RESET_PC`.
  - `redirect` high: `npc`=`redirect_pc`.
  - Granted request (`imem_req && imem_gnt`): `npc`=`pc`+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - Otherwise: `npc`=`pc`.
- `imem_req` = (state==`RUN`) && !`redirect` && (count<2) && !`clr`. It is combinational, and `imem_addr`=`pc`.
- Transitions:
  - `RUN` to `WAIT` on a granted request. `req_pc` captures `pc` on that edge.
  - `WAIT` to `RUN` on `imem_rvalid`. {`imem_rdata`, `req_pc`} is pushed to the buffer.
  - `WAIT` to `DROP` on `redirect` without `imem_rvalid`.
  - `WAIT` to `RUN` on `redirect` with `imem_rvalid`; the response is discarded.
  - `DROP` to `RUN` on `imem_rvalid`; the response is discarded. A `redirect` while in `DROP` stays in `DROP` and only updates `npc`.
- Redirect flushes the buffer: count goes to 0 on the next edge, and any pop in that cycle is ignored.
- Buffer behaviour:
  - Pop happens when `id_valid && id_ready`. Push and pop in the same cycle are legal, and count is unchanged.
  - Overflow is impossible: an issue requires count<2 with nothing outstanding.
  - Pop when empty is ignored.

## Timing
- Reset values: state=`RUN`, count=0, `req_pc`=0, `id_valid`=0, `id_inst`=0, `id_pc`=0, `imem_req`=0, `npc`=`RESET_PC`.
- Asserting `clr` mid-fetch abandons the outstanding response. Any `imem_rvalid` seen in `RUN` is ignored.
- Fetch latency: grant in cycle N, response in cycle N+k (k≥1), then `id_valid` high in cycle N+k+1.
- Peak throughput is one instruction per 2 cycles when memory responds in 1 cycle.
- `id_valid`, `id_inst` and `id_pc` are driven from buffer registers, with no combinational path from `imem_*`.
- `npc` and `imem_req` are combinational from `pc`, `redirect`, `imem_gnt`, state and count.

## Structure
- Shared package `mips_pkg` holds:
  - `RESET_PC` default;
  - the `fetch_state_t` enum (`RUN`, `WAIT`, `DROP`);
  - `INST_NOP` = 32'h0;
  - `PC_STEP` = 4.
- One sub-module, `ifetch_buf`: a 2-entry FIFO of {inst, pc} with push, pop and flush; flush has priority over push.
- FSM, `npc` mux and `req_pc` live in `ifetch_ctrl`.

## Test plan
- Reset: hold `clr` for 3 cycles with `pc`=0x40 → `npc`=0, `imem_req`=0, `id_valid`=0.
- Sequential fetch, 1-cycle memory: `pc`=0 with `id_ready`=1 → requests at 0, 4, 8 on alternate cycles; `id_pc` sequence 0, 4, 8 with matching `id_inst`.
- Backpressure: `id_ready`=0 → after 2 pushes `imem_req` stays 0 and `npc`=`pc`. One pop restarts fetch.
- Redirect in `WAIT`: `redirect_pc`=0x100 one cycle before `imem_rvalid` → response discarded, buffer empty, next request address 0x100.
- Redirect coincident with `imem_rvalid`, plus redirect in `RUN` coincident with a pop → nothing pushed, pop ignored, count=0, `npc`=`redirect_pc`.
- Wrap-around: `pc`=32'hFFFF_FFFC granted → `npc`=0.
